// File: rtl/timer_pkg.sv
// Shared types and defaults for the start-pattern-triggered delay timer.
package timer_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SHIFT  = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int                 DEF_DELAY_W        = 4;
    localparam int                 DEF_PATTERN_W      = 4;
    localparam logic [DEF_PATTERN_W-1:0] DEF_PATTERN  = 4'b1101;
    localparam int                 DEF_TICKS_PER_UNIT = 1000;

    // Width of a counter that must hold 0..ticks-1.
    function automatic int tick_cnt_w(input int ticks);
        return (ticks < 2) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/unit_tick_gen.sv
// Free-running 0..TICKS-1 prescaler with synchronous clear and a one-cycle wrap pulse.
module unit_tick_gen
    import timer_pkg::*;
#(
    parameter int TICKS = DEF_TICKS_PER_UNIT,
    parameter int W     = tick_cnt_w(TICKS)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == W'(TICKS - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/delay_timer_sequencer.sv
// Watches data for a start pattern, shifts in a delay, counts (delay+1) units,
// then holds done until ack.
module delay_timer_sequencer
    import timer_pkg::*;
#(
    parameter int                   DELAY_W        = DEF_DELAY_W,
    parameter int                   PATTERN_W      = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN        = DEF_PATTERN,
    parameter int                   TICKS_PER_UNIT = DEF_TICKS_PER_UNIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               ack,
    output logic               shift_ena,
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count
);

    localparam int BIT_W = $clog2(DELAY_W + 1);

    state_e               state_q, state_d;
    logic [PATTERN_W-2:0] hist_q, hist_d;
    logic [PATTERN_W-1:0] window;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 tick_clr;
    logic                 tick_wrap;

    unit_tick_gen #(
        .TICKS (TICKS_PER_UNIT)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (tick_clr),
        .wrap_o (tick_wrap)
    );

    assign window = {hist_q, data};
    // The delay register doubles as the remaining-units counter.
    assign count  = delay_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            delay_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            delay_q <= delay_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        delay_d  = delay_q;
        bit_d    = bit_q;
        tick_clr = 1'b0;
        case (state_q)
            SEARCH: begin
                hist_d = window[PATTERN_W-2:0];
                if (window == PATTERN) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                delay_d = {delay_q[DELAY_W-2:0], data};
                bit_d   = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(DELAY_W - 1)) begin
                    state_d  = COUNT;
                    tick_clr = 1'b1;
                end
            end
            COUNT: begin
                // The unit at count==0 is still counted, giving delay+1 units in total.
                if (tick_wrap) begin
                    if (delay_q == '0) begin
                        state_d = DONE;
                    end else begin
                        delay_d = delay_q - DELAY_W'(1);
                    end
                end
            end
            DONE: begin
                // Clearing history makes pattern bits seen during DONE irrelevant.
                if (ack) begin
                    state_d = SEARCH;
                    hist_d  = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        shift_ena = 1'b0;
        counting  = 1'b0;
        done      = 1'b0;
        case (state_q)
            SHIFT:   shift_ena = 1'b1;
            COUNT:   counting  = 1'b1;
            DONE:    done      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/delay_timer_sequencer.md
Name: delay_timer_sequencer

Overview:
Start-pattern-triggered programmable delay timer. It watches a serial data line for a start pattern, then shifts in a DELAY_W-bit delay value MSB-first. It counts (delay+1)*TICKS_PER_UNIT cycles and then raises done until the consumer acknowledges. It is the controller that sequences the shift-enable window used by our serial-capture datapaths, and it adds the count and handshake phases around that window.

Parameters:
DELAY_W, 4, width of the serially loaded delay value; also the length of the shift_ena window in cycles
PATTERN_W, 4, length of the start pattern in bits
PATTERN, 4'b1101, start pattern; oldest bit is the MSB
TICKS_PER_UNIT, 1000, clock cycles per delay unit (>=2)

Ports:
clk  input  1  clock, all logic on the rising edge
reset  input  1  synchronous, active-high; clock clk
data  input  1  serial input carrying the start pattern and then the delay bits
ack  input  1  consumer acknowledge for done
shift_ena  output  1  high during the DELAY_W delay-load cycles
counting  output  1  high during the count phase
done  output  1  high from the end of the count until ack is sampled
count  output  DELAY_W  remaining delay units

Behaviour:
- States: SEARCH, SHIFT, COUNT, DONE. Outputs are Moore-decoded from the state.
- Reset (synchronous, has priority over everything):
  - state=SEARCH, history=0, delay reg=0, bit counter=0, tick counter=0.
  - All outputs are 0 in the cycle after reset is sampled.
- SEARCH:
  - history holds the last PATTERN_W-1 sampled bits.
  - Match when {history,data}==PATTERN; matching overlaps (1,1,1,0,1 matches).
  - On a match: next state is SHIFT and the bit counter clears.
- SHIFT:
  - shift_ena=1 for exactly DELAY_W consecutive cycles, starting the cycle after the last pattern bit.
  - Each cycle: delay <= {delay[DELAY_W-2:0], data}. The first bit loaded is the MSB.
  - After the DELAY_W-th shift cycle: next state is COUNT and the tick counter clears.
  - count follows the delay register during shifting.
- COUNT:
  - counting=1.
  - The tick counter runs 0..TICKS_PER_UNIT-1 and wraps.
  - On wrap with count!=0: count decrements by 1.
  - On wrap with count==0: next state is DONE.
  - Total counting-high cycles are exactly (delay+1)*TICKS_PER_UNIT.
  - delay=0 gives TICKS_PER_UNIT cycles; the all-ones delay gives 2^DELAY_W*TICKS_PER_UNIT cycles with no overflow.
- DONE:
  - done=1 and count=0.
  - When ack=1 is sampled: next state is SEARCH and history clears to 0, so pattern bits seen before ack are ignored. done drops the cycle after ack.
- Ignored inputs:
  - ack is ignored in SEARCH, SHIFT and COUNT. An ack held high early does not shortcut DONE; DONE always lasts at least 1 cycle.
  - data is ignored in COUNT and DONE.
- shift_ena, counting and done are mutually exclusive. At most one is high in any cycle.
- Reset mid-operation (in any state): the next cycle is SEARCH with all outputs 0, and any partially shifted delay is discarded.

Decomposition:
- Shared package (timer_pkg):
  - state enum typedef (SEARCH, SHIFT, COUNT, DONE)
  - default PATTERN, PATTERN_W, DELAY_W, TICKS_PER_UNIT constants
  - tick-counter width function $clog2(TICKS_PER_UNIT)
- Sub-module unit_tick_gen:
  - Free-running 0..TICKS_PER_UNIT-1 prescaler with a synchronous clear input and a single-cycle wrap pulse.
  - Instantiated once. The FSM clears it on entry to COUNT.

Test Plan (TICKS_PER_UNIT=10 override for runtime, defaults elsewhere):
- Basic run:
  - Stimulus: reset, then data 1,1,0,1 then 0,1,0,1.
  - Response: shift_ena high exactly 4 cycles, starting the cycle after the 4th pattern bit; count=5 at COUNT entry; counting high 60 cycles; count steps 5..0 every 10 cycles; done high.
  - Then ack pulsed 3 cycles later: done drops the next cycle and the block is back in SEARCH.
- Overlap and false starts:
  - Stimulus: data 1,1,1,0,1.
  - Response: match on the 5th bit.
  - Stimulus: 1,1,0,0,1,1,0,1.
  - Response: single match on the 8th bit.
- Delay bounds:
  - delay bits 0,0,0,0: counting high exactly 10 cycles.
  - delay bits 1,1,1,1: counting high exactly 160 cycles, count starts at 15.
- Handshake:
  - ack held high continuously from before the pattern: done pulses exactly 1 cycle.
  - ack low in DONE for 50 cycles: done stays high and count=0 throughout.
- Post-ack history:
  - Stimulus: pattern bits 1,1,0 are driven during DONE, then ack, then 1.
  - Response: no match.
- Reset mid-operation:
  - Stimulus: assert reset in SHIFT after 2 bits, and in COUNT with count=3.
  - Response: next cycle all outputs 0, and a fresh 1101 is required to restart.
